// File: rtl/cache_read_arbiter.sv
// cache_read_arbiter: round-robin sharing of one AXI read channel between ICache and DCache fetches
module cache_read_arbiter #(
    parameter int LINEBEATS = 16,
    parameter int AXIDW     = 32
) (
    input  logic             Clk,
    input  logic             Rest,
    input  logic             IcaReadAble,
    input  logic             IUncacheRead,
    input  logic [31:0]      IcaReadAddr,
    input  logic             ICacheFlash,
    output logic             CacReadfree,
    output logic             IRshankhand,
    output logic             ReadBackAble,
    output logic [511:0]     ReadBackDate,
    input  logic             DcaReadAble,
    input  logic             DUncacheRead,
    input  logic [31:0]      DcaReadAddr,
    output logic             DcaReadfree,
    output logic             DRshankhand,
    output logic             DReadBackAble,
    output logic [511:0]     DReadBackDate,
    output logic             ArValid,
    input  logic             ArReady,
    output logic [31:0]      ArAddr,
    output logic [7:0]       ArLen,
    output logic [2:0]       ArSize,
    output logic [1:0]       ArBurst,
    input  logic             RValid,
    output logic             RReady,
    input  logic [AXIDW-1:0] RData,
    input  logic             RLast
);
    localparam logic [3:0] LAST_BEAT = 4'(LINEBEATS - 1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t       state_q, state_d;
    logic         gnt_d_q, gnt_d_d, last_d_q, last_d_d, cached_q, cached_d;
    logic         sat_q, sat_d, flush_q, flush_d;
    logic [31:0]  addr_q, addr_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [511:0] line_q, line_d, i_data_q, i_data_d, d_data_q, d_data_d, resp_data;
    logic         pend_i, pend_d, pick_d, grant, hs, beat;

    assign pend_i    = IcaReadAble | IUncacheRead;
    assign pend_d    = DcaReadAble | DUncacheRead;
    assign pick_d    = pend_d && (!pend_i || !last_d_q);
    assign grant     = state_q == IDLE && (pend_i || pend_d);
    assign hs        = ArValid && ArReady;
    assign beat      = RValid && RReady;
    assign resp_data = cached_q ? line_q : {{480{1'b0}}, line_q[31:0]};

    // state register
    always_ff @(posedge Clk) begin
        state_q <= Rest ? IDLE : state_d;
    end

    // next-state: grant -> address phase -> beats until RLast -> one response cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = grant ? ADDR : IDLE;
            ADDR:    state_d = hs ? DATA : ADDR;
            DATA:    state_d = beat && RLast ? RESP : DATA;
            default: state_d = IDLE;
        endcase
    end

    // outputs, all forced low while reset is asserted
    always_comb begin
        CacReadfree   = !Rest && state_q == IDLE;
        DcaReadfree   = CacReadfree;
        ArValid       = !Rest && state_q == ADDR;
        ArAddr        = !ArValid ? 32'd0 : cached_q ? {addr_q[31:6], 6'b0} : addr_q;
        ArLen         = ArValid && cached_q ? 8'(LINEBEATS - 1) : 8'd0;
        ArSize        = ArValid ? 3'b010 : 3'b000;
        ArBurst       = ArValid ? 2'b01 : 2'b00;
        IRshankhand   = ArValid && ArReady && !gnt_d_q;
        DRshankhand   = ArValid && ArReady && gnt_d_q;
        RReady        = !Rest && state_q == DATA;
        ReadBackAble  = !Rest && state_q == RESP && !gnt_d_q && !flush_q && !ICacheFlash;
        DReadBackAble = !Rest && state_q == RESP && gnt_d_q;
        ReadBackDate  = Rest ? '0 : ReadBackAble ? resp_data : i_data_q;
        DReadBackDate = Rest ? '0 : DReadBackAble ? resp_data : d_data_q;
    end

    // datapath: latch grant, assemble the line, track an I flush over the whole transaction
    always_comb begin
        gnt_d_d  = grant ? pick_d : gnt_d_q;
        last_d_d = grant ? pick_d : last_d_q;
        cached_d = grant ? (pick_d ? DcaReadAble : IcaReadAble) : cached_q;
        addr_d   = grant ? (pick_d ? DcaReadAddr : IcaReadAddr) : addr_q;
        line_d   = hs ? '0 : line_q;
        cnt_d    = hs ? 4'd0 : cnt_q;
        sat_d    = hs ? 1'b0 : sat_q;
        if (beat && !sat_q) begin
            line_d[AXIDW*int'(cnt_q) +: AXIDW] = RData;
            cnt_d = cnt_q == LAST_BEAT ? cnt_q : cnt_q + 4'd1;
            sat_d = cnt_q == LAST_BEAT;
        end
        flush_d  = state_q == RESP ? 1'b0
                 : flush_q | (ICacheFlash && (state_q == IDLE ? grant && !pick_d : !gnt_d_q));
        i_data_d = ReadBackAble ? resp_data : i_data_q;
        d_data_d = DReadBackAble ? resp_data : d_data_q;
    end

    // datapath registers; LastGrant resets to D so I wins the first tie
    always_ff @(posedge Clk) begin
        if (Rest) begin
            gnt_d_q  <= 1'b0;
            last_d_q <= 1'b1;
            cached_q <= 1'b0;
            addr_q   <= '0;
            line_q   <= '0;
            cnt_q    <= '0;
            sat_q    <= 1'b0;
            flush_q  <= 1'b0;
            i_data_q <= '0;
            d_data_q <= '0;
        end else begin
            gnt_d_q  <= gnt_d_d;
            last_d_q <= last_d_d;
            cached_q <= cached_d;
            addr_q   <= addr_d;
            line_q   <= line_d;
            cnt_q    <= cnt_d;
            sat_q    <= sat_d;
            flush_q  <= flush_d;
            i_data_q <= i_data_d;
            d_data_q <= d_data_d;
        end
    end
endmodule

// File: tb/tb_cache_read_arbiter.sv
// tb_cache_read_arbiter: directed transactions with a queue-based scoreboard on the AR and readback sides
module tb_cache_read_arbiter;
    localparam int LB = 16;
    localparam int DW = 32;

    logic          Clk = 0, Rest = 1;
    logic          IcaReadAble = 0, IUncacheRead = 0, ICacheFlash = 0;
    logic [31:0]   IcaReadAddr = 0;
    logic          DcaReadAble = 0, DUncacheRead = 0;
    logic [31:0]   DcaReadAddr = 0;
    logic          ArReady = 0, RValid = 0, RLast = 0;
    logic [DW-1:0] RData = 0;
    logic          CacReadfree, IRshankhand, ReadBackAble, DcaReadfree, DRshankhand, DReadBackAble;
    logic [511:0]  ReadBackDate, DReadBackDate;
    logic          ArValid, RReady;
    logic [31:0]   ArAddr;
    logic [7:0]    ArLen;
    logic [2:0]    ArSize;
    logic [1:0]    ArBurst;

    cache_read_arbiter #(.LINEBEATS(LB), .AXIDW(DW)) dut (
        .Clk(Clk), .Rest(Rest),
        .IcaReadAble(IcaReadAble), .IUncacheRead(IUncacheRead), .IcaReadAddr(IcaReadAddr),
        .ICacheFlash(ICacheFlash), .CacReadfree(CacReadfree), .IRshankhand(IRshankhand),
        .ReadBackAble(ReadBackAble), .ReadBackDate(ReadBackDate),
        .DcaReadAble(DcaReadAble), .DUncacheRead(DUncacheRead), .DcaReadAddr(DcaReadAddr),
        .DcaReadfree(DcaReadfree), .DRshankhand(DRshankhand),
        .DReadBackAble(DReadBackAble), .DReadBackDate(DReadBackDate),
        .ArValid(ArValid), .ArReady(ArReady), .ArAddr(ArAddr), .ArLen(ArLen),
        .ArSize(ArSize), .ArBurst(ArBurst),
        .RValid(RValid), .RReady(RReady), .RData(RData), .RLast(RLast)
    );

    always #5 Clk = ~Clk;

    typedef struct {logic d; logic [31:0] addr; logic [7:0] len;} ar_t;
    typedef struct {logic d; logic [511:0] data;} rb_t;

    ar_t exp_ar[$];
    rb_t exp_rb[$];
    ar_t ea;
    rb_t er;
    int  pass_cnt = 0;
    int  total = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [511:0] idx_line(input int n);
        logic [511:0] l = '0;
        for (int k = 0; k < n && k < LB; k++) l[k*DW +: DW] = DW'(k);
        return l;
    endfunction

    function automatic logic [511:0] uext(input logic [31:0] w);
        return {480'd0, w};
    endfunction

    function automatic logic any_out();
        return |{CacReadfree, IRshankhand, ReadBackAble, ReadBackDate, DcaReadfree, DRshankhand,
                 DReadBackAble, DReadBackDate, ArValid, ArAddr, ArLen, ArSize, ArBurst, RReady};
    endfunction

    task automatic expect_txn(input logic d, input logic [31:0] addr, input logic [7:0] len,
                              input logic pulse, input logic [511:0] data);
        exp_ar.push_back('{d, addr, len});
        if (pulse) exp_rb.push_back('{d, data});
    endtask

    // AXI slave side of one transaction: ArReady low for wt cycles, then nb beats
    task automatic serve(input logic d, input int wt, input int nb, input logic idx,
                         input logic [31:0] dat, input int flush_at, input int rst_at,
                         input logic pulse, output int n);
        logic [31:0] a0;
        logic rst_hit = 0;
        n = 0;
        @(negedge Clk);
        while (!ArValid && n < 20) begin
            @(negedge Clk);
            n++;
        end
        chk("arvalid_seen", ArValid, 1);
        a0 = ArAddr;
        for (int k = 0; k < wt; k++) begin
            chk("addr_hold", {ArValid, ArAddr, CacReadfree, DcaReadfree, IRshankhand, DRshankhand},
                {1'b1, a0, 4'b0});
            @(posedge Clk); #1;
            if (k < wt - 1) @(negedge Clk);
        end
        ArReady = 1;
        @(negedge Clk);
        chk("addr_hs", {ArValid, ArAddr}, {1'b1, a0});
        @(posedge Clk); #1;
        ArReady = 0;
        if (d) begin
            DcaReadAble = 0;
            DUncacheRead = 0;
        end else begin
            IcaReadAble = 0;
            IUncacheRead = 0;
        end
        for (int b = 0; b < nb && !rst_hit; b++) begin
            RValid = 1;
            RData = idx ? DW'(b) : dat;
            RLast = (b == nb - 1);
            ICacheFlash = (b == flush_at);
            if (b == rst_at) begin
                Rest = 1;
                rst_hit = 1;
            end
            @(negedge Clk);
            if (rst_hit) chk("rst_outs", any_out(), 0);
            else chk("rready", RReady, 1);
            @(posedge Clk); #1;
        end
        RValid = 0;
        RLast = 0;
        ICacheFlash = 0;
        if (rst_hit) begin
            @(negedge Clk);
            chk("rst_next", any_out(), 0);
            @(posedge Clk); #1;
            Rest = 0;
            @(negedge Clk);
            chk("rst_idle", {CacReadfree, DcaReadfree, ArValid, RReady}, 4'b1100);
        end else begin
            @(negedge Clk);
            chk("rb_pulse", {ReadBackAble, DReadBackAble}, pulse ? (d ? 2'b01 : 2'b10) : 2'b00);
        end
    endtask

    // monitor: compare every AR handshake and every readback pulse against the queues
    always @(negedge Clk) begin
        if (!Rest) begin
            if (ArValid && ArReady) begin
                chk("ar_expected", exp_ar.size() != 0, 1);
                if (exp_ar.size() != 0) begin
                    ea = exp_ar.pop_front();
                    chk("ar_addr", ArAddr, ea.addr);
                    chk("ar_len", ArLen, ea.len);
                    chk("ar_size_burst", {ArSize, ArBurst}, 5'b01001);
                    chk("ar_shake", {IRshankhand, DRshankhand}, ea.d ? 2'b01 : 2'b10);
                end
            end else if (IRshankhand || DRshankhand) begin
                chk("shake_stray", {IRshankhand, DRshankhand}, 0);
            end
            if (ReadBackAble || DReadBackAble) begin
                chk("rb_expected", exp_rb.size() != 0, 1);
                if (exp_rb.size() != 0) begin
                    er = exp_rb.pop_front();
                    chk("rb_side", {ReadBackAble, DReadBackAble}, er.d ? 2'b01 : 2'b10);
                    chk("rb_data", er.d ? DReadBackDate : ReadBackDate, er.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk("reset_outs", any_out(), 0);
        @(posedge Clk); #1;
        Rest = 0;
        @(negedge Clk);
        chk("free_after_reset", {CacReadfree, DcaReadfree}, 2'b11);

        // simultaneous I and D: I first, D right after I's response
        @(posedge Clk); #1;
        IcaReadAble = 1; IcaReadAddr = 32'h0000_1000;
        DcaReadAble = 1; DcaReadAddr = 32'h0000_2040;
        expect_txn(0, 32'h0000_1000, 8'd15, 1, idx_line(16));
        serve(0, 1, 16, 1, 0, -1, -1, 1, n);
        expect_txn(1, 32'h0000_2040, 8'd15, 1, idx_line(16));
        @(negedge Clk);
        chk("b2b_grant_free", DcaReadfree, 1);
        serve(1, 1, 16, 1, 0, -1, -1, 1, n);
        chk("b2b_addr_next", n, 0);

        // second tie goes to I again; D sets cached and uncached together
        @(posedge Clk); #1;
        IUncacheRead = 1; IcaReadAddr = 32'h0000_3004;
        DcaReadAble = 1; DUncacheRead = 1; DcaReadAddr = 32'h0000_4044;
        expect_txn(0, 32'h0000_3004, 8'd0, 1, uext(32'h1111_2222));
        serve(0, 1, 1, 0, 32'h1111_2222, -1, -1, 1, n);
        expect_txn(1, 32'h0000_4040, 8'd15, 1, idx_line(16));
        serve(1, 2, 16, 1, 0, -1, -1, 1, n);
        @(negedge Clk);
        chk("i_data_hold", ReadBackDate, uext(32'h1111_2222));
        chk("d_data_hold", DReadBackDate, idx_line(16));

        // I cached line fill with beat-index data
        @(posedge Clk); #1;
        IcaReadAble = 1; IcaReadAddr = 32'h1C00_00A4;
        expect_txn(0, 32'h1C00_0080, 8'd15, 1, idx_line(16));
        serve(0, 1, 16, 1, 0, -1, -1, 1, n);

        // D uncached single word
        @(posedge Clk); #1;
        DUncacheRead = 1; DcaReadAddr = 32'h1FE0_01E0;
        expect_txn(1, 32'h1FE0_01E0, 8'd0, 1, uext(32'hDEAD_BEEF));
        serve(1, 1, 1, 0, 32'hDEAD_BEEF, -1, -1, 1, n);

        // ArReady held low for 5 cycles
        @(posedge Clk); #1;
        IUncacheRead = 1; IcaReadAddr = 32'h0000_0100;
        expect_txn(0, 32'h0000_0100, 8'd0, 1, uext(32'h0BAD_F00D));
        serve(0, 5, 1, 0, 32'h0BAD_F00D, -1, -1, 1, n);

        // I flush during beat 7 suppresses the response, next I request is normal
        @(posedge Clk); #1;
        IcaReadAble = 1; IcaReadAddr = 32'h2000_0010;
        expect_txn(0, 32'h2000_0000, 8'd15, 0, '0);
        serve(0, 1, 16, 1, 0, 7, -1, 0, n);
        @(posedge Clk); #1;
        IcaReadAble = 1; IcaReadAddr = 32'h2000_0040;
        expect_txn(0, 32'h2000_0040, 8'd15, 1, idx_line(16));
        serve(0, 1, 16, 1, 0, -1, -1, 1, n);

        // early RLast leaves the remaining words zero
        @(posedge Clk); #1;
        IcaReadAble = 1; IcaReadAddr = 32'h0000_0300;
        expect_txn(0, 32'h0000_0300, 8'd15, 1, idx_line(4));
        serve(0, 1, 4, 1, 0, -1, -1, 1, n);

        // beats past the line end are dropped
        @(posedge Clk); #1;
        DcaReadAble = 1; DcaReadAddr = 32'h0000_0500;
        expect_txn(1, 32'h0000_0500, 8'd15, 1, idx_line(16));
        serve(1, 1, 18, 1, 0, -1, -1, 1, n);

        // ICacheFlash does not touch a D transaction
        @(posedge Clk); #1;
        DcaReadAble = 1; DcaReadAddr = 32'h0000_0600;
        expect_txn(1, 32'h0000_0600, 8'd15, 1, idx_line(16));
        serve(1, 1, 16, 1, 0, 2, -1, 1, n);

        // reset during beat 3 abandons the transaction
        @(posedge Clk); #1;
        IcaReadAble = 1; IcaReadAddr = 32'h0000_0700;
        expect_txn(0, 32'h0000_0700, 8'd15, 0, '0);
        serve(0, 1, 16, 1, 0, -1, 3, 0, n);

        @(posedge Clk); #1;
        IcaReadAble = 1; IcaReadAddr = 32'h0000_0800;
        expect_txn(0, 32'h0000_0800, 8'd15, 1, idx_line(16));
        serve(0, 1, 16, 1, 0, -1, -1, 1, n);

        repeat (2) @(negedge Clk);
        chk("ar_drained", exp_ar.size(), 0);
        chk("rb_drained", exp_rb.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
